ethpipe_rx_slot_reader: RTL and testbench
=========================================

# ethpipe_rx_slot_reader

Drains one received Ethernet frame from the RX frame slot RAM in the PCIe clock domain and emits it as a 32-bit word stream (length/timestamp/hash header, then frame bytes) toward the host DMA path. It sits on the PCIe side of the RX slot, consumes the per-frame completion pulse produced by the GMII receive path, and hands the slot back by raising `slot_rx_empty` once the frame has been fully streamed or dropped.

## Interface
- `MAX_FRAME_LEN`, 1518: largest accepted frame length in bytes, FCS included. Legal range 1..8172.
- `pci_clk` in 1: PCIe clock (125 MHz). This is the only clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `slot_rx_complete` in 1: single-cycle pulse, already synchronised to `pci_clk`. It means the slot holds a complete frame.
- `slot_rx_empty` out 1: high while the slot is free for the receiver to fill.
- `slot_rx_rd_address` out 11: slot RAM read word address.
- `slot_rx_rd_q` in 32: slot RAM read data. Synchronous, valid one cycle after the address.
- `out_data` out 32: stream word.
- `out_byte_en` out 4: valid bytes of `out_data`, bit n covers [8n+7:8n].
- `out_sop` out 1: first word of a frame.
- `out_eop` out 1: last word of a frame.
- `out_valid` out 1: word available.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.
- `frame_count` out 32: frames streamed. Wraps.
- `drop_count` out 16: frames dropped for bad length. Wraps.
- `overrun` out 1: sticky. Set when `slot_rx_complete` arrives outside IDLE.

## Operation
- Slot layout (word addresses):
  - 1: timestamp[31:0].
  - 2: timestamp[63:32].
  - 3: hash.
  - 4: length, bits [13:0], in bytes including FCS.
  - 5 onward: frame bytes. Frame byte k is at address 5 + k/4, bits [8(k%4)+7 : 8(k%4)].
- States:
  - IDLE: `slot_rx_empty`=1. On `slot_rx_complete` go to LEN and drive address 4.
  - LEN: latch `len = q[13:0]`.
    - If `len == 0` or `len > MAX_FRAME_LEN`, go to RELEASE and increment `drop_count`.
    - Otherwise go to STREAM.
  - STREAM: emit the header, then the data words (detailed below). After the handshake of the eop word, go to RELEASE.
  - RELEASE: one cycle. Increment `frame_count` if the frame was streamed. Go to IDLE.
- STREAM emits header words in this order:
  - `{18'h0, len}` with `out_sop`=1.
  - timestamp low.
  - timestamp high.
  - hash.
- STREAM then emits `ceil(len/4)` data words from addresses 5 onward.
  - `out_byte_en`=4'b1111 on every word except the last.
  - On the last word, by `len%4`: 0 gives 1111, 1 gives 0001, 2 gives 0011, 3 gives 0111.
  - Bytes not enabled in the last word are passed through from RAM unchanged.
- Total words per frame = 4 + ceil(len/4). `out_eop`=1 only on the last word.
- Read order is 4, 1, 2, 3, 5, 6, … Address arithmetic is 11-bit. The maximum legal address is 5 + 2042 = 2047, so addresses never wrap.
- Backpressure:
  - While `out_valid && !out_ready`, `out_data`, `out_byte_en`, `out_sop` and `out_eop` hold stable.
  - `out_valid` never drops before its handshake.
  - Reads that are already in flight are buffered (2-entry skid) and never re-issued out of order.
- `slot_rx_complete` while not in IDLE: ignored and `overrun` is set. Only reset clears `overrun`.
- `slot_rx_complete` in the same cycle as the RELEASE→IDLE transition: ignored and sets `overrun`. The receiver cannot legally produce this case.

## Timing
- Reset values:
  - `slot_rx_empty`=1.
  - `out_valid`=0, `out_sop`=0, `out_eop`=0.
  - `out_data`=0, `out_byte_en`=0.
  - `slot_rx_rd_address`=0.
  - `frame_count`=0, `drop_count`=0, `overrun`=0.
  - State = IDLE.
- Reset asserted mid-frame: the partial frame is abandoned with no eop, and all outputs go to their reset values immediately. The slot contents are then treated as free.
- Latency, with cycle 0 = cycle in which `slot_rx_complete` is sampled high:
  - Cycle 1: `slot_rx_empty` is 0 and address 4 is driven.
  - Cycle 3: `out_valid` with the sop word. No cycle later than this is allowed.
- Throughput: with `out_ready` held high, one word per cycle from sop to eop, with no bubbles.
- Drop path: `slot_rx_empty` returns to 1 by cycle 4, with `out_valid` never asserted.
- Release point: `slot_rx_empty` rises exactly 2 cycles after the eop handshake (RELEASE, then IDLE).
- Counters update in the RELEASE cycle.

## Test plan
- Frame `len=64`, timestamp 0x0000_0001_2345_6789, hash 0, `out_ready`=1:
  - 20 words: 0x40, 0x23456789, 0x1, 0x0, then 16 data words, all with `byte_en` 1111.
  - sop on word 0, eop on word 19.
  - `frame_count`=1; `slot_rx_empty` rises 2 cycles after eop.
- `len=61`: 16 data words, last word `byte_en`=0001. `len=62` gives 0011 and `len=63` gives 0111.
- `out_ready` toggled pseudo-randomly during a `len=1518` frame:
  - 384 words (4 header + 380 data), in order, with no loss or duplicates.
  - Outputs stable while stalled.
- Length word 0 and length word 1519:
  - No `out_valid`; `drop_count`=2, `frame_count` unchanged.
  - `slot_rx_empty` back to 1 within 4 cycles of each pulse.
- Second `slot_rx_complete` pulse mid-stream: `overrun`=1, and the current frame completes intact.
- `sys_rst_n` pulled low at word 10 of a frame:
  - Outputs go to reset values asynchronously and `slot_rx_empty`=1.
  - The next frame streams correctly from sop.

Source files
------------

// File: rtl/ethpipe_rx_slot_reader.sv
// Drains one frame from the RX slot RAM as a 32-bit word stream:
// length, timestamp low/high and hash header words, then the frame data words.
module ethpipe_rx_slot_reader #(
   parameter int unsigned MAX_FRAME_LEN = 1518
) (
   input  logic        pci_clk,
   input  logic        sys_rst_n,
   input  logic        slot_rx_complete,
   output logic        slot_rx_empty,
   output logic [10:0] slot_rx_rd_address,
   input  logic [31:0] slot_rx_rd_q,
   output logic [31:0] out_data,
   output logic [3:0]  out_byte_en,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] frame_count,
   output logic [15:0] drop_count,
   output logic        overrun
);

   typedef enum logic [2:0] {StIdle, StAddr, StLen, StStream, StRelease} state_e;

   state_e state_q, state_d;

   logic [10:0] addr_q, addr_d;
   logic [12:0] rd_left_q, rd_left_d;
   logic [1:0]  len_mod_q, len_mod_d;
   logic        drop_q, drop_d;
   logic        pend_vld_q, pend_vld_d, pend_last_q, pend_last_d;
   logic [31:0] fifo_data_q [2];
   logic [31:0] fifo_data_d [2];
   logic        fifo_last_q [2];
   logic        fifo_last_d [2];
   logic        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic [1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  be_q, be_d, be_last;
   logic        sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        ovr_q, ovr_d;

   logic [31:0] len_w;
   logic        len_ok, pop, load, rd_en, rd_last, take_pend, fifo_push, fifo_pop;
   logic [2:0]  occ;

   assign len_w  = {18'd0, slot_rx_rd_q[13:0]};
   assign len_ok = (len_w != 32'd0) && (len_w <= MAX_FRAME_LEN);
   assign pop    = valid_q && out_ready;
   assign load   = !valid_q || out_ready;
   // Words held after this edge; one more read may be issued only if it is sure to find room.
   assign occ    = {2'b0, valid_q} + {1'b0, fifo_cnt_q} + {2'b0, pend_vld_q} - {2'b0, pop};

   // State register
   always_ff @(posedge pci_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (slot_rx_complete) state_d = StAddr;
         StAddr:    state_d = StLen;
         StLen:     state_d = len_ok ? StStream : StRelease;
         StStream:  if (pop && eop_q) state_d = StRelease;
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      slot_rx_empty = (state_q == StIdle);
   end

   always_comb begin
      unique case (len_mod_q)
         2'd1:    be_last = 4'b0001;
         2'd2:    be_last = 4'b0011;
         2'd3:    be_last = 4'b0111;
         default: be_last = 4'b1111;
      endcase
   end

   // Read issue: address 4 first, then 1, 2, 3, 5, 6, ...
   always_comb begin
      rd_en     = 1'b0;
      rd_last   = 1'b0;
      addr_d    = addr_q;
      rd_left_d = rd_left_q;
      len_mod_d = len_mod_q;
      drop_d    = drop_q;
      if (state_q == StLen) begin
         rd_en     = len_ok;
         len_mod_d = slot_rx_rd_q[1:0];
         drop_d    = !len_ok;
         rd_left_d = {1'b0, slot_rx_rd_q[13:2]} + {12'd0, |slot_rx_rd_q[1:0]} + 13'd2;
      end else if (state_q == StStream) begin
         rd_en   = (rd_left_q != 13'd0) && (occ <= 3'd2);
         rd_last = (rd_left_q == 13'd1);
         if (rd_en) rd_left_d = rd_left_q - 13'd1;
      end
      if (state_q == StIdle) begin
         if (slot_rx_complete) addr_d = 11'd4;
      end else if (state_q == StAddr) begin
         addr_d = 11'd1;
      end else if (rd_en) begin
         addr_d = (addr_q == 11'd3) ? 11'd5 : addr_q + 11'd1;
      end
      pend_vld_d  = rd_en;
      pend_last_d = rd_last;
   end

   // Output register fed from the skid FIFO first, then from the word arriving from RAM.
   always_comb begin
      valid_d     = valid_q;
      data_d      = data_q;
      be_d        = be_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      take_pend   = 1'b0;
      fifo_pop    = 1'b0;
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      if (state_q == StLen && len_ok) begin
         valid_d = 1'b1;
         data_d  = len_w;
         be_d    = 4'b1111;
         sop_d   = 1'b1;
         eop_d   = 1'b0;
      end else if (load) begin
         sop_d = 1'b0;
         if (fifo_cnt_q != 2'd0) begin
            fifo_pop = 1'b1;
            valid_d  = 1'b1;
            data_d   = fifo_data_q[fifo_rd_q];
            eop_d    = fifo_last_q[fifo_rd_q];
            be_d     = fifo_last_q[fifo_rd_q] ? be_last : 4'b1111;
         end else if (pend_vld_q) begin
            take_pend = 1'b1;
            valid_d   = 1'b1;
            data_d    = slot_rx_rd_q;
            eop_d     = pend_last_q;
            be_d      = pend_last_q ? be_last : 4'b1111;
         end else begin
            valid_d = 1'b0;
            eop_d   = 1'b0;
         end
      end
      fifo_push = pend_vld_q && !take_pend;
      if (fifo_push) begin
         fifo_data_d[fifo_wr_q] = slot_rx_rd_q;
         fifo_last_d[fifo_wr_q] = pend_last_q;
      end
      fifo_wr_d  = fifo_wr_q ^ fifo_push;
      fifo_rd_d  = fifo_rd_q ^ fifo_pop;
      fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (state_q == StRelease) begin
         if (drop_q) drop_cnt_d  = drop_cnt_q + 16'd1;
         else        frame_cnt_d = frame_cnt_q + 32'd1;
      end
      ovr_d = ovr_q | (slot_rx_complete && (state_q != StIdle));
   end

   always_ff @(posedge pci_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         addr_q      <= 11'd0;
         rd_left_q   <= 13'd0;
         len_mod_q   <= 2'd0;
         drop_q      <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_last_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= 32'd0;
            fifo_last_q[i] <= 1'b0;
         end
         fifo_wr_q   <= 1'b0;
         fifo_rd_q   <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         data_q      <= 32'd0;
         be_q        <= 4'd0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         valid_q     <= 1'b0;
         frame_cnt_q <= 32'd0;
         drop_cnt_q  <= 16'd0;
         ovr_q       <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         rd_left_q   <= rd_left_d;
         len_mod_q   <= len_mod_d;
         drop_q      <= drop_d;
         pend_vld_q  <= pend_vld_d;
         pend_last_q <= pend_last_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         fifo_wr_q   <= fifo_wr_d;
         fifo_rd_q   <= fifo_rd_d;
         fifo_cnt_q  <= fifo_cnt_d;
         data_q      <= data_d;
         be_q        <= be_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         valid_q     <= valid_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         ovr_q       <= ovr_d;
      end
   end

   assign slot_rx_rd_address = addr_q;
   assign out_data           = data_q;
   assign out_byte_en        = be_q;
   assign out_sop            = sop_q;
   assign out_eop            = eop_q;
   assign out_valid          = valid_q;
   assign frame_count        = frame_cnt_q;
   assign drop_count         = drop_cnt_q;
   assign overrun            = ovr_q;

endmodule

// File: tb/tb_ethpipe_rx_slot_reader.sv
// Directed bench for ethpipe_rx_slot_reader with a synchronous slot RAM model.
module tb_ethpipe_rx_slot_reader;

   logic        pci_clk = 1'b0;
   logic        sys_rst_n;
   logic        slot_rx_complete;
   logic        slot_rx_empty;
   logic [10:0] slot_rx_rd_address;
   logic [31:0] slot_rx_rd_q;
   logic [31:0] out_data;
   logic [3:0]  out_byte_en;
   logic        out_sop, out_eop, out_valid, out_ready;
   logic [31:0] frame_count;
   logic [15:0] drop_count;
   logic        overrun;

   logic [31:0] mem [0:2047];
   int tests = 0;
   int fails = 0;

   always #4 pci_clk = ~pci_clk;

   always @(posedge pci_clk) slot_rx_rd_q <= mem[slot_rx_rd_address];

   ethpipe_rx_slot_reader #(.MAX_FRAME_LEN(1518)) dut (
      .pci_clk            (pci_clk),
      .sys_rst_n          (sys_rst_n),
      .slot_rx_complete   (slot_rx_complete),
      .slot_rx_empty      (slot_rx_empty),
      .slot_rx_rd_address (slot_rx_rd_address),
      .slot_rx_rd_q       (slot_rx_rd_q),
      .out_data           (out_data),
      .out_byte_en        (out_byte_en),
      .out_sop            (out_sop),
      .out_eop            (out_eop),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .frame_count        (frame_count),
      .drop_count         (drop_count),
      .overrun            (overrun)
   );

   task automatic load_slot(input int len, input logic [63:0] ts, input logic [31:0] hash,
                            input logic [31:0] seed);
      logic [31:0] lw;
      lw     = len;
      mem[1] = ts[31:0];
      mem[2] = ts[63:32];
      mem[3] = hash;
      mem[4] = 32'hA5A5_C000 | {18'd0, lw[13:0]};
      for (int i = 0; i < 2043; i++) mem[5 + i] = seed + 32'(i) * 32'h9E37_79B1;
   endtask

   task automatic test_reset();
      sys_rst_n        = 1'b0;
      slot_rx_complete = 1'b0;
      out_ready        = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
      #20;
      tests++;
      if ({out_valid, out_sop, out_eop, out_data, out_byte_en, slot_rx_rd_address} !== 50'd0 ||
          slot_rx_empty !== 1'b1 || frame_count !== 32'd0 || drop_count !== 16'd0 ||
          overrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_values: valid=%b data=%h be=%h addr=%h empty=%b fc=%0d dc=%0d ovr=%b, want all zero and empty=1",
                  out_valid, out_data, out_byte_en, slot_rx_rd_address, slot_rx_empty,
                  frame_count, drop_count, overrun);
      end
      @(negedge pci_clk);
      sys_rst_n = 1'b1;
      @(negedge pci_clk);
   endtask

   // Streams one frame; rnd toggles out_ready, pulse_at fires a stray completion on that word,
   // abort_at pulls reset when that word is reached.
   task automatic run_frame(input int len, input bit rnd, input int pulse_at, input int abort_at,
                            input int exp_frames, input bit exp_ovr);
      int          nwords, j, bubbles;
      bit          done, ready, prev_stall;
      logic [38:0] prev, cur;
      logic [37:0] got, exp;
      logic [31:0] lw, ed;
      logic [3:0]  eb;
      nwords = 4 + (len + 3) / 4;
      lw     = len;
      @(negedge pci_clk);
      slot_rx_complete = 1'b1;
      out_ready        = 1'b1;
      @(negedge pci_clk);
      slot_rx_complete = 1'b0;
      tests++;
      if (slot_rx_empty !== 1'b0 || slot_rx_rd_address !== 11'd4) begin
         fails++;
         $display("FAIL cycle1: empty=%b addr=%0d, want empty=0 addr=4", slot_rx_empty,
                  slot_rx_rd_address);
      end
      @(negedge pci_clk);
      @(negedge pci_clk);
      tests++;
      if ({out_valid, out_sop} !== 2'b11) begin
         fails++;
         $display("FAIL cycle3_sop: valid=%b sop=%b, want 1 1", out_valid, out_sop);
      end
      j = 0; done = 1'b0; bubbles = 0; prev_stall = 1'b0; prev = '0;
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         if (cyc > 0) @(negedge pci_clk);
         slot_rx_complete = 1'b0;
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cur   = {out_data, out_byte_en, out_sop, out_eop, out_valid};
         if (prev_stall) begin
            tests++;
            if (cur !== prev) begin
               fails++;
               $display("FAIL stall_stable: word %0d now %h, held value %h", j, cur, prev);
            end
         end
         if (!rnd && !out_valid) bubbles++;
         if (abort_at >= 0 && j == abort_at) begin
            sys_rst_n = 1'b0;
            #1;
            tests++;
            if ({out_valid, out_sop, out_eop, out_data, out_byte_en, slot_rx_rd_address} !== 50'd0 ||
                slot_rx_empty !== 1'b1 || frame_count !== 32'd0 || overrun !== 1'b0) begin
               fails++;
               $display("FAIL async_reset: valid=%b data=%h be=%h addr=%h empty=%b fc=%0d ovr=%b, want zeros empty=1",
                        out_valid, out_data, out_byte_en, slot_rx_rd_address, slot_rx_empty,
                        frame_count, overrun);
            end
            @(negedge pci_clk);
            @(negedge pci_clk);
            sys_rst_n = 1'b1;
            out_ready = 1'b1;
            return;
         end
         out_ready  = ready;
         prev_stall = out_valid && !ready;
         prev       = cur;
         if (out_valid && ready) begin
            if (j == 0)     ed = {18'd0, lw[13:0]};
            else if (j < 4) ed = mem[j];
            else            ed = mem[5 + j - 4];
            eb = 4'b1111;
            if (j == nwords - 1) begin
               case (len % 4)
                  1:       eb = 4'b0001;
                  2:       eb = 4'b0011;
                  3:       eb = 4'b0111;
                  default: eb = 4'b1111;
               endcase
            end
            exp = {ed, eb, j == 0, j == nwords - 1};
            got = {out_data, out_byte_en, out_sop, out_eop};
            tests++;
            if (got !== exp) begin
               fails++;
               $display("FAIL word_%0d len=%0d: data=%h be=%b sop=%b eop=%b, want data=%h be=%b sop=%b eop=%b",
                        j, len, out_data, out_byte_en, out_sop, out_eop, ed, eb, j == 0,
                        j == nwords - 1);
            end
            if (j == pulse_at) slot_rx_complete = 1'b1;
            if (j == nwords - 1) done = 1'b1;
            j++;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL frame_timeout len=%0d: got %0d words, want %0d", len, j, nwords);
      end
      @(negedge pci_clk);
      slot_rx_complete = 1'b0;
      tests++;
      if (slot_rx_empty !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL release_cycle: empty=%b valid=%b, want 0 0", slot_rx_empty, out_valid);
      end
      @(negedge pci_clk);
      tests++;
      if (slot_rx_empty !== 1'b1 || frame_count !== 32'(exp_frames) || overrun !== exp_ovr) begin
         fails++;
         $display("FAIL after_release len=%0d: empty=%b fc=%0d ovr=%b, want empty=1 fc=%0d ovr=%b",
                  len, slot_rx_empty, frame_count, overrun, exp_frames, exp_ovr);
      end
      if (!rnd) begin
         tests++;
         if (bubbles != 0) begin
            fails++;
            $display("FAIL throughput len=%0d: %0d bubble cycles, want 0", len, bubbles);
         end
      end
   endtask

   task automatic test_drop(input int len, input int exp_drops, input int exp_frames);
      load_slot(len, 64'h0BAD_0BAD_0BAD_0BAD, 32'h1234_5678, 32'h0);
      @(negedge pci_clk);
      slot_rx_complete = 1'b1;
      out_ready        = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge pci_clk);
         slot_rx_complete = 1'b0;
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_valid len=%0d cycle %0d: valid=%b, want 0", len, c, out_valid);
         end
      end
      tests++;
      if (slot_rx_empty !== 1'b1 || drop_count !== 16'(exp_drops) ||
          frame_count !== 32'(exp_frames)) begin
         fails++;
         $display("FAIL drop_counts len=%0d: empty=%b dc=%0d fc=%0d, want 1 %0d %0d", len,
                  slot_rx_empty, drop_count, frame_count, exp_drops, exp_frames);
      end
   endtask

   task automatic test_basic_64();
      load_slot(64, 64'h0000_0001_2345_6789, 32'h0, 32'hC0DE_0000);
      run_frame(64, 1'b0, -1, -1, 1, 1'b0);
   endtask

   task automatic test_tail_bytes();
      load_slot(61, 64'h1111_2222_3333_4444, 32'hDEAD_BEEF, 32'h0101_0101);
      run_frame(61, 1'b0, -1, -1, 2, 1'b0);
      load_slot(62, 64'h5555_6666_7777_8888, 32'hFEED_F00D, 32'h0202_0202);
      run_frame(62, 1'b0, -1, -1, 3, 1'b0);
      load_slot(63, 64'h9999_AAAA_BBBB_CCCC, 32'hCAFE_BABE, 32'h0303_0303);
      run_frame(63, 1'b0, -1, -1, 4, 1'b0);
   endtask

   task automatic test_bad_length();
      test_drop(0, 1, 4);
      test_drop(1519, 2, 4);
   endtask

   task automatic test_backpressure_1518();
      load_slot(1518, 64'hFEDC_BA98_7654_3210, 32'h0F0F_F0F0, 32'h7777_0000);
      run_frame(1518, 1'b1, -1, -1, 5, 1'b0);
   endtask

   task automatic test_overrun();
      load_slot(100, 64'h0000_0000_0000_0042, 32'h0000_0099, 32'h4242_4242);
      run_frame(100, 1'b0, 5, -1, 6, 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      load_slot(200, 64'h0123_4567_89AB_CDEF, 32'h5555_AAAA, 32'h1357_9BDF);
      run_frame(200, 1'b0, -1, 10, 0, 1'b0);
      load_slot(64, 64'h0000_0001_2345_6789, 32'h0, 32'h2468_ACE0);
      run_frame(64, 1'b0, -1, -1, 1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic_64();
      test_tail_bytes();
      test_bad_length();
      test_backpressure_1518();
      test_overrun();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
